generation_scheduler: RTL and testbench
=======================================

// Module: generation_scheduler
// PURPOSE
//  Sequences one Game-of-Life generation over the ping-pong BRAM pair (A/B).
//  Issues row fetch addresses to the line buffer and counts next-state writes.
//  Flips the bank-select mode only at a video frame boundary.
//  Sits between video timing, the run/pause controls and the BRAM mode selector.
// PARAMETERS
//  Y_SIZE   720  rows per generation
//  Y_WIDTH  10   row address width, clog2(Y_SIZE)
//  GEN_W    16   generation counter width
// PORTS
//  clk             in   1        system clock; all logic on rising edge
//  rst             in   1        synchronous, active-high reset
//  run             in   1        1 = free-run generations; 0 = paused
//  step            in   1        1-cycle pulse: compute one generation while paused
//  frame_end       in   1        1-cycle pulse from video timing, end of active frame
//  fetch_ready     in   1        line buffer accepts fetch_addr this cycle
//  fetch_valid     out  1        fetch_addr valid
//  fetch_addr      out  Y_WIDTH  row to read from the read bank
//  result_valid    in   1        next-state pipeline has a result row
//  write_addr      out  Y_WIDTH  row address for the write bank
//  write_en        out  1        write strobe to the write bank
//  mode            out  1        1: read A / write B; 0: read B / write A
//  busy            out  1        generation in progress (not IDLE)
//  gen_count       out  GEN_W    completed (swapped) generations, wraps
//  overrun         out  1        sticky: result_valid seen with no row left
// BEHAVIOUR
//  Reset: state=IDLE. fetch_valid=0, fetch_addr=0, write_addr=0, write_en=0.
//   Also mode=0, busy=0, gen_count=0, overrun=0. Reset wins over every other input.
//  States: IDLE -> FETCH -> DRAIN -> WAIT_SWAP -> IDLE.
//  IDLE:
//   - Go to FETCH next cycle if run=1, or if step=1 while run=0.
//   - Fetch and write counters cleared to 0.
//   - step while run=1 is ignored.
//  FETCH:
//   - fetch_valid=1 and fetch_addr holds the current fetch row.
//   - A row is accepted on a cycle with fetch_valid & fetch_ready.
//   - On acceptance fetch_addr increments; hold on no acceptance.
//   - After row Y_SIZE-1 is accepted: fetch_valid=0 next cycle, go to DRAIN.
//  Writes (FETCH and DRAIN):
//   - write_en = result_valid, combinational, same cycle.
//   - write_addr = write counter; counter increments on each write.
//   - When write row Y_SIZE-1 is written, go to WAIT_SWAP next cycle.
//   - Writes may complete while still in FETCH; then go FETCH -> WAIT_SWAP only once
//     fetch is also complete.
//  result_valid outside FETCH/DRAIN, or after Y_SIZE writes:
//   - write_en forced 0 and overrun set (sticky until rst).
//  WAIT_SWAP:
//   - Hold until frame_end. On the frame_end cycle: mode toggles and gen_count+1,
//     both visible next cycle. Go to IDLE.
//  frame_end in IDLE/FETCH/DRAIN is ignored: no swap, no count.
//   A generation longer than one frame simply waits for the next frame_end.
//  Pause: run 1->0 mid-generation does not abort.
//   The generation completes and swaps; the block then stays in IDLE.
//  Back-to-back: in IDLE with run=1, FETCH starts the cycle after the swap.
//   Minimum is one IDLE cycle per generation.
//  busy=1 in FETCH, DRAIN and WAIT_SWAP.
//  mode never changes except on a WAIT_SWAP frame_end. The read bank is stable for a
//   whole displayed frame and a whole generation.
//  gen_count wraps 2^GEN_W-1 -> 0.
//  Reset mid-generation: IDLE next cycle, mode=0. Partial write-bank content is
//   don't-care.
// TESTING (bench uses Y_SIZE=8, Y_WIDTH=3)
//  1 Reset, run=1, fetch_ready=1, result_valid 2 cycles after each fetch:
//    fetch_addr 0..7 on consecutive cycles.
//    write_addr 0..7 with write_en; frame_end -> mode 0->1, gen_count=1.
//  2 fetch_ready toggling 1/0:
//    each fetch_addr held until accepted; exactly 8 acceptances, no skipped or
//    repeated rows.
//  3 run=0, single step pulse:
//    one generation, one swap on the next frame_end, then IDLE.
//    Further frame_end pulses leave mode and gen_count unchanged.
//  4 frame_end pulsed during FETCH and DRAIN:
//    no mode change; swap occurs only on the first frame_end after WAIT_SWAP entry.
//  5 9th result_valid in a generation, and result_valid in IDLE:
//    write_en=0, overrun=1 and stays 1 until rst.
//  6 rst asserted at fetch_addr=4:
//    next cycle IDLE with all outputs at reset values; run=1 restarts from row 0.

Source files
------------

// File: rtl/generation_scheduler.sv
// Game-of-Life generation sequencer: fetches Y_SIZE rows, counts Y_SIZE result writes,
// then flips the ping-pong bank select on the next video frame boundary.
module generation_scheduler #(
   parameter int Y_SIZE  = 720,
   parameter int Y_WIDTH = 10,
   parameter int GEN_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               step,
   input  logic               frame_end,
   input  logic               fetch_ready,
   output logic               fetch_valid,
   output logic [Y_WIDTH-1:0] fetch_addr,
   input  logic               result_valid,
   output logic [Y_WIDTH-1:0] write_addr,
   output logic               write_en,
   output logic               mode,
   output logic               busy,
   output logic [GEN_W-1:0]   gen_count,
   output logic               overrun
);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] FETCH     = 2'd1;
   localparam logic [1:0] DRAIN     = 2'd2;
   localparam logic [1:0] WAIT_SWAP = 2'd3;

   localparam logic [Y_WIDTH-1:0] LAST_ROW = Y_WIDTH'(Y_SIZE - 1);

   logic [1:0]         state;
   logic [Y_WIDTH-1:0] fetch_cnt;
   logic [Y_WIDTH-1:0] write_cnt;
   logic               write_done;
   logic               write_window;
   logic               accept;
   logic               last_fetch;
   logic               last_write;

   // write_done covers the case where all results land before the last fetch is accepted
   assign write_window = ((state == FETCH) || (state == DRAIN)) && !write_done;
   assign write_en     = result_valid && write_window;
   assign fetch_valid  = (state == FETCH);
   assign accept       = fetch_valid && fetch_ready;
   assign last_fetch   = accept && (fetch_cnt == LAST_ROW);
   assign last_write   = write_en && (write_cnt == LAST_ROW);
   assign fetch_addr   = fetch_cnt;
   assign write_addr   = write_cnt;
   assign busy         = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         fetch_cnt  <= '0;
         write_cnt  <= '0;
         write_done <= 1'b0;
         mode       <= 1'b0;
         gen_count  <= '0;
         overrun    <= 1'b0;
      end else begin
         if (result_valid && !write_window)
            overrun <= 1'b1;
         if (accept)
            fetch_cnt <= fetch_cnt + 1'b1;
         if (write_en)
            write_cnt <= write_cnt + 1'b1;

         case (state)
            IDLE: begin
               fetch_cnt  <= '0;
               write_cnt  <= '0;
               write_done <= 1'b0;
               if (run || step)
                  state <= FETCH;
            end
            FETCH: begin
               if (last_write)
                  write_done <= 1'b1;
               if (last_fetch)
                  state <= (write_done || last_write) ? WAIT_SWAP : DRAIN;
            end
            DRAIN: begin
               if (last_write)
                  state <= WAIT_SWAP;
            end
            WAIT_SWAP: begin
               // the bank select only moves here, so the read bank stays put for a whole frame
               if (frame_end) begin
                  mode      <= ~mode;
                  gen_count <= gen_count + 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_generation_scheduler.sv
// Bench for generation_scheduler with an 8-row generation and a 4-bit generation counter.
module tb_generation_scheduler;
   localparam int Y  = 8;
   localparam int YW = 3;
   localparam int GW = 4;

   logic          clk;
   logic          rst;
   logic          run;
   logic          step;
   logic          frame_end;
   logic          fetch_ready;
   logic          fetch_valid;
   logic [YW-1:0] fetch_addr;
   logic          result_valid;
   logic [YW-1:0] write_addr;
   logic          write_en;
   logic          mode;
   logic          busy;
   logic [GW-1:0] gen_count;
   logic          overrun;

   generation_scheduler #(.Y_SIZE(Y), .Y_WIDTH(YW), .GEN_W(GW)) dut (
      .clk(clk), .rst(rst), .run(run), .step(step), .frame_end(frame_end),
      .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
      .result_valid(result_valid), .write_addr(write_addr), .write_en(write_en),
      .mode(mode), .busy(busy), .gen_count(gen_count), .overrun(overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // line-buffer emulation: a result row follows each accepted fetch by two cycles
   bit p0 = 0, p1 = 0, acc_q = 0;
   bit auto_rv = 0, force_rv = 0, toggle_ready = 0;
   int acc_log[$];
   int acc_cyc[$];
   int wr_seen = 0;

   // behavioural model: a generation is "active" until swapped; phase follows from row counts
   bit m_active = 0, m_mode = 0, m_overrun = 0;
   int m_fetched = 0, m_written = 0, m_gen = 0;

   task automatic cmp(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      bit e_fv, e_wok, e_we, e_wait;
      e_fv   = m_active && (m_fetched < Y);
      e_wok  = m_active && (m_written < Y);
      e_we   = result_valid && e_wok;
      e_wait = m_active && (m_fetched == Y) && (m_written == Y);
      cmp("fetch_valid", int'(fetch_valid), int'(e_fv));
      if (e_fv) cmp("fetch_addr", int'(fetch_addr), m_fetched % Y);
      cmp("write_en", int'(write_en), int'(e_we));
      if (e_wok) cmp("write_addr", int'(write_addr), m_written);
      cmp("mode", int'(mode), int'(m_mode));
      cmp("busy", int'(busy), int'(m_active));
      cmp("gen_count", int'(gen_count), m_gen);
      cmp("overrun", int'(overrun), int'(m_overrun));

      acc_q = fetch_valid && fetch_ready;
      if (acc_q) begin
         acc_log.push_back(int'(fetch_addr));
         acc_cyc.push_back(cyc);
      end
      if (write_en) wr_seen++;

      if (rst) begin
         m_active = 0; m_mode = 0; m_overrun = 0;
         m_fetched = 0; m_written = 0; m_gen = 0;
      end else begin
         if (result_valid && !e_wok) m_overrun = 1;
         if (!m_active) begin
            if (run || step) begin
               m_active = 1; m_fetched = 0; m_written = 0;
            end
         end else begin
            if (e_fv && fetch_ready) m_fetched++;
            if (e_we) m_written++;
            if (e_wait && frame_end) begin
               m_active = 0;
               m_mode   = !m_mode;
               m_gen    = (m_gen + 1) % (1 << GW);
            end
         end
      end
   end

   task automatic drive_rv();
      result_valid = (p1 && auto_rv) || force_rv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      p1 = p0;
      p0 = acc_q;
      if (toggle_ready) fetch_ready = !fetch_ready;
      drive_rv();
      #1;
   endtask

   task automatic clear_logs();
      acc_log.delete();
      acc_cyc.delete();
      wr_seen = 0;
   endtask

   task automatic wait_ready(input int lim);
      int n = 0;
      while (!(m_active && m_fetched == Y && m_written == Y) && n < lim) begin
         tick();
         n++;
      end
      if (!(m_active && m_fetched == Y && m_written == Y)) begin
         checks++;
         errors++;
         $display("FAIL wait_swap_timeout: got %0d fetched %0d written, required %0d each", m_fetched, m_written, Y);
      end
   endtask

   task automatic pulse_frame_end();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
   endtask

   task automatic pulse_step();
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   task automatic check_rows(input string nm);
      cmp({nm, "_rows"}, acc_log.size(), Y);
      for (int i = 0; i < Y; i++)
         if (i < acc_log.size()) cmp({nm, "_row"}, acc_log[i], i);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      p0 = 0; p1 = 0;
      drive_rv();
   endtask

   initial begin
      int n;
      rst = 1'b1; run = 1'b0; step = 1'b0; frame_end = 1'b0;
      fetch_ready = 1'b0; result_valid = 1'b0;
      tick();
      tick();
      cmp("rst_fetch_valid", int'(fetch_valid), 0);
      cmp("rst_fetch_addr", int'(fetch_addr), 0);
      cmp("rst_write_addr", int'(write_addr), 0);
      cmp("rst_write_en", int'(write_en), 0);
      cmp("rst_mode", int'(mode), 0);
      cmp("rst_busy", int'(busy), 0);
      cmp("rst_gen", int'(gen_count), 0);
      cmp("rst_overrun", int'(overrun), 0);
      rst = 1'b0;

      // 1: free run, always ready
      clear_logs();
      fetch_ready = 1'b1; auto_rv = 1'b1; run = 1'b1;
      wait_ready(40);
      run = 1'b0;
      check_rows("t1");
      if (acc_cyc.size() == Y) cmp("t1_consecutive", acc_cyc[Y-1] - acc_cyc[0], Y - 1);
      cmp("t1_writes", wr_seen, Y);
      cmp("t1_mode_before", int'(mode), 0);
      pulse_frame_end();
      cmp("t1_mode", int'(mode), 1);
      cmp("t1_gen", int'(gen_count), 1);

      // 2: fetch_ready toggling
      clear_logs();
      toggle_ready = 1'b1; run = 1'b1;
      wait_ready(60);
      run = 1'b0;
      check_rows("t2");
      cmp("t2_writes", wr_seen, Y);
      pulse_frame_end();
      toggle_ready = 1'b0; fetch_ready = 1'b1;
      cmp("t2_gen", int'(gen_count), 2);
      cmp("t2_mode", int'(mode), 0);

      // 3: single step while paused, extra frame_end ignored
      clear_logs();
      pulse_step();
      wait_ready(40);
      check_rows("t3");
      pulse_frame_end();
      repeat (3) begin
         tick();
         pulse_frame_end();
      end
      cmp("t3_gen", int'(gen_count), 3);
      cmp("t3_mode", int'(mode), 1);
      cmp("t3_busy", int'(busy), 0);

      // 4: frame_end during FETCH and DRAIN
      pulse_step();
      tick();
      pulse_frame_end();
      n = 0;
      while (!(m_fetched == Y && m_written < Y) && n < 40) begin
         tick();
         n++;
      end
      cmp("t4_reach_drain", int'(m_fetched == Y && m_written < Y), 1);
      pulse_frame_end();
      cmp("t4_gen_held", int'(gen_count), 3);
      wait_ready(40);
      repeat (3) tick();
      cmp("t4_waiting_busy", int'(busy), 1);
      cmp("t4_mode_held", int'(mode), 1);
      pulse_frame_end();
      cmp("t4_gen", int'(gen_count), 4);
      cmp("t4_mode", int'(mode), 0);

      // 5a: ninth result in WAIT_SWAP
      pulse_step();
      wait_ready(40);
      force_rv = 1'b1; drive_rv();
      tick();
      force_rv = 1'b0; drive_rv();
      cmp("t5_overrun_wait", int'(overrun), 1);
      pulse_frame_end();
      repeat (3) tick();
      cmp("t5_overrun_sticky", int'(overrun), 1);
      cmp("t5_gen", int'(gen_count), 5);

      // 5b: result in IDLE
      reset_dut();
      cmp("t5_overrun_cleared", int'(overrun), 0);
      force_rv = 1'b1; drive_rv();
      tick();
      force_rv = 1'b0; drive_rv();
      cmp("t5_overrun_idle", int'(overrun), 1);

      // 5c: all writes finish inside FETCH, then a ninth
      reset_dut();
      clear_logs();
      fetch_ready = 1'b0; auto_rv = 1'b0;
      pulse_step();
      force_rv = 1'b1; drive_rv();
      repeat (Y + 1) tick();
      force_rv = 1'b0; drive_rv();
      cmp("t5_writes_in_fetch", wr_seen, Y);
      cmp("t5_overrun_fetch", int'(overrun), 1);
      cmp("t5_still_fetching", int'(fetch_valid), 1);
      fetch_ready = 1'b1;
      wait_ready(20);
      check_rows("t5");
      pulse_frame_end();
      cmp("t5_gen_after", int'(gen_count), 1);

      // 6: reset at row 4, then restart
      reset_dut();
      p0 = 0; p1 = 0; auto_rv = 1'b1; run = 1'b1; fetch_ready = 1'b1;
      drive_rv();
      n = 0;
      while (!(fetch_valid && fetch_addr == 3'd4) && n < 20) begin
         tick();
         n++;
      end
      cmp("t6_reach_row4", int'(fetch_valid && fetch_addr == 3'd4), 1);
      rst = 1'b1; auto_rv = 1'b0; drive_rv();
      tick();
      p0 = 0; p1 = 0;
      cmp("t6_busy", int'(busy), 0);
      cmp("t6_fetch_valid", int'(fetch_valid), 0);
      cmp("t6_fetch_addr", int'(fetch_addr), 0);
      cmp("t6_write_addr", int'(write_addr), 0);
      cmp("t6_mode", int'(mode), 0);
      cmp("t6_overrun", int'(overrun), 0);
      rst = 1'b0; auto_rv = 1'b1; drive_rv();
      clear_logs();
      wait_ready(40);
      check_rows("t6");
      pulse_frame_end();
      cmp("t6_gen", int'(gen_count), 1);
      cmp("t6_mode_after", int'(mode), 1);

      // back-to-back generations through the counter wrap
      repeat (15) begin
         wait_ready(40);
         pulse_frame_end();
      end
      run = 1'b0;
      cmp("wrap_gen", int'(gen_count), 0);
      cmp("wrap_mode", int'(mode), 0);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
